// File: rtl/wb_write_scheduler_pkg.sv
// Shared constants, status/icode encodings and FSM state for the Writeback write scheduler.
package wb_write_scheduler_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned REG_AW = 4;
    localparam int unsigned CNT_W  = 32;

    localparam logic [REG_AW-1:0] RNONE = 4'hF;
    localparam logic [REG_AW-1:0] RSP   = 4'h4;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SECOND = 2'd1,
        S_HALTED = 2'd2
    } wb_state_e;

    // Instructions whose dstE/dstM fields may name a real register.
    function automatic logic icode_writes(input logic [3:0] icode);
        case (icode)
            I_RRMOVQ, I_IRMOVQ, I_MRMOVQ, I_OPQ,
            I_CALL, I_RET, I_PUSHQ, I_POPQ: icode_writes = 1'b1;
            default:                        icode_writes = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/wb_write_scheduler_qualify.sv
// Decides which Writeback writes are real and whether the instruction halts the machine.
module wb_write_qualify
    import wb_write_scheduler_pkg::*;
(
    input  logic [3:0]        icode,
    input  logic [1:0]        stat,
    input  logic [REG_AW-1:0] dst_e,
    input  logic [REG_AW-1:0] dst_m,
    output logic              we_e_c,
    output logic              we_m_c,
    output logic              halt_req_c
);

    logic aok_wr;

    assign aok_wr     = (stat == STAT_AOK) && icode_writes(icode);
    assign we_e_c     = aok_wr && (dst_e != RNONE);
    assign we_m_c     = aok_wr && (dst_m != RNONE);
    assign halt_req_c = (stat != STAT_AOK);

endmodule

// File: rtl/wb_write_scheduler.sv
// Serialises W-stage register writes onto one register-file port; E before M, halts on bad stat.
// Optional WB_FWD_EN exposes the pending M write for decode forwarding.
module wb_write_scheduler
    import wb_write_scheduler_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              W_valid,
    input  logic [1:0]        W_stat,
    input  logic [3:0]        W_icode,
    input  logic [DATA_W-1:0] W_valE,
    input  logic [DATA_W-1:0] W_valM,
    input  logic [REG_AW-1:0] W_dstE,
    input  logic [REG_AW-1:0] W_dstM,
    output logic              W_stall,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              halted,
    output logic [1:0]        halt_stat,
    output logic [CNT_W-1:0]  retired_cnt
`ifdef WB_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_reg,
    output logic [DATA_W-1:0] fwd_val
`endif
);

    wb_state_e         state_q, state_d;
    logic              rf_we_q, rf_we_d;
    logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              halted_q, halted_d;
    logic [1:0]        halt_stat_q, halt_stat_d;
    logic [CNT_W-1:0]  retired_cnt_q, retired_cnt_d;
    logic [REG_AW-1:0] pend_reg_q, pend_reg_d;
    logic [DATA_W-1:0] pend_val_q, pend_val_d;

    logic we_e, we_m, halt_req;

    wb_write_qualify u_qualify (
        .icode      (W_icode),
        .stat       (W_stat),
        .dst_e      (W_dstE),
        .dst_m      (W_dstM),
        .we_e_c     (we_e),
        .we_m_c     (we_m),
        .halt_req_c (halt_req)
    );

    always_comb begin
        state_d       = state_q;
        rf_we_d       = 1'b0;
        rf_waddr_d    = rf_waddr_q;
        rf_wdata_d    = rf_wdata_q;
        halted_d      = halted_q;
        halt_stat_d   = halt_stat_q;
        retired_cnt_d = retired_cnt_q;
        pend_reg_d    = pend_reg_q;
        pend_val_d    = pend_val_q;

        case (state_q)
            S_IDLE: begin
                if (W_valid) begin
                    if (halt_req) begin
                        state_d     = S_HALTED;
                        halted_d    = 1'b1;
                        halt_stat_d = W_stat;
                    end else if (we_e) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = W_dstE;
                        rf_wdata_d = W_valE;
                        if (we_m) begin
                            // Retirement is counted when the deferred M write issues.
                            state_d    = S_SECOND;
                            pend_reg_d = W_dstM;
                            pend_val_d = W_valM;
                        end else begin
                            retired_cnt_d = retired_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        if (we_m) begin
                            rf_we_d    = 1'b1;
                            rf_waddr_d = W_dstM;
                            rf_wdata_d = W_valM;
                        end
                        retired_cnt_d = retired_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_SECOND: begin
                state_d       = S_IDLE;
                rf_we_d       = 1'b1;
                rf_waddr_d    = pend_reg_q;
                rf_wdata_d    = pend_val_q;
                retired_cnt_d = retired_cnt_q + CNT_W'(1);
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= '0;
            rf_wdata_q    <= '0;
            halted_q      <= 1'b0;
            halt_stat_q   <= 2'd0;
            retired_cnt_q <= '0;
            pend_reg_q    <= '0;
            pend_val_q    <= '0;
        end else begin
            state_q       <= state_d;
            rf_we_q       <= rf_we_d;
            rf_waddr_q    <= rf_waddr_d;
            rf_wdata_q    <= rf_wdata_d;
            halted_q      <= halted_d;
            halt_stat_q   <= halt_stat_d;
            retired_cnt_q <= retired_cnt_d;
            pend_reg_q    <= pend_reg_d;
            pend_val_q    <= pend_val_d;
        end
    end

    assign W_stall     = (state_q == S_SECOND) || (state_q == S_HALTED);
    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign halted      = halted_q;
    assign halt_stat   = halt_stat_q;
    assign retired_cnt = retired_cnt_q;

`ifdef WB_FWD_EN
    assign fwd_valid = (state_q == S_SECOND);
    assign fwd_reg   = pend_reg_q;
    assign fwd_val   = pend_val_q;
`endif

endmodule

// File: tb/tb_wb_write_scheduler.sv
// Scoreboard bench for wb_write_scheduler: expected writes queued at drive time, popped on rf_we.
module tb_wb_write_scheduler;

    logic        clk;
    logic        rst_n;
    logic        W_valid;
    logic [1:0]  W_stat;
    logic [3:0]  W_icode;
    logic [63:0] W_valE;
    logic [63:0] W_valM;
    logic [3:0]  W_dstE;
    logic [3:0]  W_dstM;
    logic        W_stall;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        halted;
    logic [1:0]  halt_stat;
    logic [31:0] retired_cnt;
`ifdef WB_FWD_EN
    logic        fwd_valid;
    logic [3:0]  fwd_reg;
    logic [63:0] fwd_val;
`endif

    typedef struct packed {
        logic [3:0]  addr;
        logic [63:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          n_vec;
    int          n_err;
    logic [31:0] exp_cnt;

    wb_write_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .W_valid     (W_valid),
        .W_stat      (W_stat),
        .W_icode     (W_icode),
        .W_valE      (W_valE),
        .W_valM      (W_valM),
        .W_dstE      (W_dstE),
        .W_dstM      (W_dstM),
        .W_stall     (W_stall),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .halted      (halted),
        .halt_stat   (halt_stat),
        .retired_cnt (retired_cnt)
`ifdef WB_FWD_EN
        ,
        .fwd_valid   (fwd_valid),
        .fwd_reg     (fwd_reg),
        .fwd_val     (fwd_val)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic icode_wr(input logic [3:0] ic);
        case (ic)
            4'h2, 4'h3, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Each write pulse is seen exactly once at the falling edge.
    always @(negedge clk) begin
        if (rst_n && rf_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {60'd0, rf_waddr}, 64'hFFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", {60'd0, rf_waddr}, {60'd0, e.addr});
                check("wr_data", rf_wdata, e.data);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] st, input logic [3:0] ic,
                         input logic [63:0] ve, input logic [63:0] vm,
                         input logic [3:0] de, input logic [3:0] dm);
        W_valid = v;
        W_stat  = st;
        W_icode = ic;
        W_valE  = ve;
        W_valM  = vm;
        W_dstE  = de;
        W_dstM  = dm;
    endtask

    task automatic idle_in;
        drive(1'b0, 2'd0, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_we"},    {63'd0, rf_we}, 64'd0);
        check({tag, "_addr"},  {60'd0, rf_waddr}, 64'd0);
        check({tag, "_data"},  rf_wdata, 64'd0);
        check({tag, "_halt"},  {63'd0, halted}, 64'd0);
        check({tag, "_hstat"}, {62'd0, halt_stat}, 64'd0);
        check({tag, "_cnt"},   {32'd0, retired_cnt}, 64'd0);
        check({tag, "_stall"}, {63'd0, W_stall}, 64'd0);
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        exp_cnt = 32'd0;
        rst_n   = 1'b0;
        idle_in();
        #12;
        check_reset_outs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // irmovq $0x10,%rax
        drive(1'b1, 2'd0, 4'h3, 64'h10, 64'h0, 4'h0, 4'hF);
        exp_q.push_back('{addr: 4'h0, data: 64'h10});
        tick();
        idle_in();
        exp_cnt++;
        check("irmov_we", {63'd0, rf_we}, 64'd1);
        check("irmov_stall", {63'd0, W_stall}, 64'd0);
        check("irmov_cnt", {32'd0, retired_cnt}, {32'd0, exp_cnt});
        tick();
        check("idle_we", {63'd0, rf_we}, 64'd0);
        check("hold_addr", {60'd0, rf_waddr}, 64'd0);
        check("hold_data", rf_wdata, 64'h10);

        // popq %rbx: E then M, one stall cycle
        drive(1'b1, 2'd0, 4'hB, 64'h108, 64'hBEEF, 4'h4, 4'h3);
        exp_q.push_back('{addr: 4'h4, data: 64'h108});
        exp_q.push_back('{addr: 4'h3, data: 64'hBEEF});
        tick();
        check("pop_stall1", {63'd0, W_stall}, 64'd1);
        check("pop_cnt_mid", {32'd0, retired_cnt}, {32'd0, exp_cnt});
`ifdef WB_FWD_EN
        check("fwd_valid", {63'd0, fwd_valid}, 64'd1);
        check("fwd_reg", {60'd0, fwd_reg}, 64'd3);
        check("fwd_val", fwd_val, 64'hBEEF);
`endif
        tick();
        idle_in();
        exp_cnt++;
        check("pop_stall2", {63'd0, W_stall}, 64'd0);
        check("pop_we2", {63'd0, rf_we}, 64'd1);
        check("pop_cnt", {32'd0, retired_cnt}, {32'd0, exp_cnt});
`ifdef WB_FWD_EN
        check("fwd_valid_off", {63'd0, fwd_valid}, 64'd0);
`endif

        // popq %rsp: same register, valM must land last
        drive(1'b1, 2'd0, 4'hB, 64'h108, 64'h55, 4'h4, 4'h4);
        exp_q.push_back('{addr: 4'h4, data: 64'h108});
        exp_q.push_back('{addr: 4'h4, data: 64'h55});
        tick();
        tick();
        idle_in();
        exp_cnt++;
        check("rsp_final_addr", {60'd0, rf_waddr}, 64'd4);
        check("rsp_final_data", rf_wdata, 64'h55);

        // rmmovq and nop: no writes even with real-looking destinations
        drive(1'b1, 2'd0, 4'h4, 64'h77, 64'h88, 4'h2, 4'h3);
        tick();
        exp_cnt++;
        check("rmmov_we", {63'd0, rf_we}, 64'd0);
        drive(1'b1, 2'd0, 4'h1, 64'h99, 64'h0, 4'h5, 4'hF);
        tick();
        idle_in();
        exp_cnt++;
        check("nop_we", {63'd0, rf_we}, 64'd0);
        check("nonwr_cnt", {32'd0, retired_cnt}, {32'd0, exp_cnt});

        // mrmovq with only dstM qualified
        drive(1'b1, 2'd0, 4'h5, 64'h1, 64'hCAFE, 4'hF, 4'h6);
        exp_q.push_back('{addr: 4'h6, data: 64'hCAFE});
        tick();
        idle_in();
        exp_cnt++;
        check("mrmov_cnt", {32'd0, retired_cnt}, {32'd0, exp_cnt});

        // random AOK traffic against a reference qualification model
        for (int i = 0; i < 24; i++) begin
            logic [3:0]  ic, de, dm;
            logic [63:0] ve, vm;
            logic        qe, qm;
            ic = 4'($urandom_range(0, 11));
            de = 4'($urandom_range(0, 15));
            dm = 4'($urandom_range(0, 15));
            ve = {$urandom, $urandom};
            vm = {$urandom, $urandom};
            qe = icode_wr(ic) && (de != 4'hF);
            qm = icode_wr(ic) && (dm != 4'hF);
            drive(1'b1, 2'd0, ic, ve, vm, de, dm);
            if (qe) exp_q.push_back('{addr: de, data: ve});
            if (qm) exp_q.push_back('{addr: dm, data: vm});
            tick();
            if (qe && qm) begin
                check("rnd_stall", {63'd0, W_stall}, 64'd1);
                tick();
            end
            idle_in();
            exp_cnt++;
            check("rnd_cnt", {32'd0, retired_cnt}, {32'd0, exp_cnt});
            if ($urandom_range(0, 2) == 0) tick();
        end

        // ADR on mrmovq: halt, later instructions ignored
        drive(1'b1, 2'd2, 4'h5, 64'h5, 64'h6, 4'hF, 4'h7);
        tick();
        check("adr_we", {63'd0, rf_we}, 64'd0);
        check("adr_halted", {63'd0, halted}, 64'd1);
        check("adr_hstat", {62'd0, halt_stat}, 64'd2);
        check("adr_stall", {63'd0, W_stall}, 64'd1);
        check("adr_cnt", {32'd0, retired_cnt}, {32'd0, exp_cnt});
        drive(1'b1, 2'd0, 4'h6, 64'h1234, 64'h0, 4'h1, 4'hF);
        tick();
        tick();
        tick();
        check("halt_we", {63'd0, rf_we}, 64'd0);
        check("halt_sticky", {63'd0, halted}, 64'd1);
        check("halt_cnt", {32'd0, retired_cnt}, {32'd0, exp_cnt});
        idle_in();

        // reset from HALTED, then reset in the middle of a popq
        rst_n = 1'b0;
        #1;
        check_reset_outs("rst1");
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 32'd0;
        tick();
        drive(1'b1, 2'd0, 4'hB, 64'h200, 64'hDEAD, 4'h4, 4'h3);
        exp_q.push_back('{addr: 4'h4, data: 64'h200});
        tick();
        check("mid_stall", {63'd0, W_stall}, 64'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        idle_in();
        #1;
        check_reset_outs("rst2");
        tick();
        check("rst_hold_we", {63'd0, rf_we}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_we", {63'd0, rf_we}, 64'd0);
        drive(1'b1, 2'd0, 4'h3, 64'h42, 64'h0, 4'h0, 4'hF);
        exp_q.push_back('{addr: 4'h0, data: 64'h42});
        tick();
        idle_in();
        exp_cnt++;
        check("post_rst_cnt", {32'd0, retired_cnt}, {32'd0, exp_cnt});
        tick();
        tick();

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
